// File: rtl/rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq
// Purpose  : Reset release sequencer at the root of a clock domain's reset
//            tree. Keeps every staged reset asserted until the PLL/MMCM lock
//            indication has been stable for LOCK_FILTER cycles, waits
//            HOLD_CYCLES, then releases stage_rst[0..NUM_STAGES-1] one at a
//            time, STAGE_GAP cycles apart. Lock loss or a software request
//            re-asserts everything.
// Ports    : clk           - domain clock
//            rst_n         - asynchronous active-low reset
//            pll_locked    - lock indication, asynchronous to clk
//            soft_rst_req  - software reset request, sampled each cycle
//            stage_rst     - active-high staged resets, bit 0 released first
//            rst_done      - high once every stage_rst bit is released
//            lock_lost_cnt - saturating count of lock-loss events
// Revision : 1.0 - initial release
// ============================================================================
module rst_seq #(
  parameter int NUM_STAGES  = 3,
  parameter int LOCK_FILTER = 8,
  parameter int HOLD_CYCLES = 1024,
  parameter int STAGE_GAP   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  soft_rst_req,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  rst_done,
  output logic [7:0]            lock_lost_cnt
);

  localparam int FILT_W = $clog2(LOCK_FILTER + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int GAP_W  = $clog2(STAGE_GAP + 1);

  localparam logic [1:0] c_ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] c_ST_HOLD      = 2'd1;
  localparam logic [1:0] c_ST_RELEASE   = 2'd2;
  localparam logic [1:0] c_ST_DONE      = 2'd3;

  localparam logic [FILT_W-1:0]     c_FILT_LAST = FILT_W'(LOCK_FILTER - 1);
  localparam logic [HOLD_W-1:0]     c_HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]      c_GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [NUM_STAGES-1:0] c_ALL_ONES  = {NUM_STAGES{1'b1}};
  // Stages release as a thermometer code shifting left, so the pattern
  // with only the MSB still set marks the final release.
  localparam logic [NUM_STAGES-1:0] c_MSB_ONLY  = NUM_STAGES'(1) << (NUM_STAGES - 1);

  // --------------------------------------------------------------------------
  // Lock synchronizer
  // --------------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;
  logic w_locked_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pll_locked;
      r_sync2 <= r_sync1;
    end
  end

  assign w_locked_s = r_sync2;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]            r_state;
  logic [FILT_W-1:0]     r_filt_cnt;
  logic [HOLD_W-1:0]     r_hold_cnt;
  logic [GAP_W-1:0]      r_gap_cnt;
  logic [NUM_STAGES-1:0] r_stage_rst;
  logic                  r_rst_done;
  logic [7:0]            r_lost_cnt;

  logic [1:0]            w_state_nxt;
  logic [FILT_W-1:0]     w_filt_nxt;
  logic [HOLD_W-1:0]     w_hold_nxt;
  logic [GAP_W-1:0]      w_gap_nxt;
  logic                  w_lock_loss;
  logic                  w_soft;
  logic                  w_release;
  logic                  w_last_stage;
  logic [NUM_STAGES-1:0] w_stage_nxt;
  logic                  w_done_nxt;
  logic [7:0]            w_lost_nxt;

  assign w_last_stage = (r_stage_rst == c_MSB_ONLY);

  // State and counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_ST_WAIT_LOCK;
      r_filt_cnt <= '0;
      r_hold_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_filt_cnt <= w_filt_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gap_cnt  <= w_gap_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Counters default to zero so that every state entry
  // starts its counter from a clean value; each counter leaves its state on
  // the terminal count and therefore never wraps.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_filt_nxt  = '0;
    w_hold_nxt  = '0;
    w_gap_nxt   = '0;
    w_lock_loss = 1'b0;
    w_soft      = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      c_ST_WAIT_LOCK: begin
        if (w_locked_s) begin
          if (r_filt_cnt == c_FILT_LAST) begin
            w_state_nxt = c_ST_HOLD;
          end else begin
            w_filt_nxt = r_filt_cnt + 1'b1;
          end
        end
      end
      c_ST_HOLD: begin
        if (!w_locked_s) begin
          w_lock_loss = 1'b1;
          w_state_nxt = c_ST_WAIT_LOCK;
        end else if (r_hold_cnt == c_HOLD_LAST) begin
          w_release   = 1'b1;
          w_state_nxt = w_last_stage ? c_ST_DONE : c_ST_RELEASE;
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      c_ST_RELEASE: begin
        if (!w_locked_s) begin
          w_lock_loss = 1'b1;
          w_state_nxt = c_ST_WAIT_LOCK;
        end else if (r_gap_cnt == c_GAP_LAST) begin
          w_release   = 1'b1;
          w_state_nxt = w_last_stage ? c_ST_DONE : c_ST_RELEASE;
        end else begin
          w_gap_nxt = r_gap_cnt + 1'b1;
        end
      end
      c_ST_DONE: begin
        // Lock loss takes priority over a simultaneous software request.
        if (!w_locked_s) begin
          w_lock_loss = 1'b1;
          w_state_nxt = c_ST_WAIT_LOCK;
        end else if (soft_rst_req) begin
          w_soft      = 1'b1;
          w_state_nxt = c_ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = c_ST_WAIT_LOCK;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output next-value logic (outputs are registered below)
  // --------------------------------------------------------------------------
  always_comb begin
    w_stage_nxt = r_stage_rst;
    w_done_nxt  = r_rst_done;
    w_lost_nxt  = r_lost_cnt;
    if (w_lock_loss) begin
      w_stage_nxt = c_ALL_ONES;
      w_done_nxt  = 1'b0;
      w_lost_nxt  = (r_lost_cnt == 8'hFF) ? r_lost_cnt : r_lost_cnt + 8'd1;
    end else if (w_soft) begin
      w_stage_nxt = c_ALL_ONES;
      w_done_nxt  = 1'b0;
    end else if (w_release) begin
      w_stage_nxt = r_stage_rst << 1;
      w_done_nxt  = w_last_stage;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage_rst <= c_ALL_ONES;
      r_rst_done  <= 1'b0;
      r_lost_cnt  <= 8'd0;
    end else begin
      r_stage_rst <= w_stage_nxt;
      r_rst_done  <= w_done_nxt;
      r_lost_cnt  <= w_lost_nxt;
    end
  end

  assign stage_rst     = r_stage_rst;
  assign rst_done      = r_rst_done;
  assign lock_lost_cnt = r_lost_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_rst_seq
// Purpose  : Self-checking bench for rst_seq (3 stages, filter 4, hold 10,
//            gap 3). Expected output transitions (edge number and value) are
//            queued when stimulus is applied; a monitor pops one entry for
//            every observed output change and compares edge and value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rst_seq;

  localparam int LF = 4;
  localparam int HC = 10;
  localparam int G  = 3;
  localparam int T0 = 2 + LF + HC;  // edge of stage_rst[0] release after edge 1

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic [2:0] stage_rst;
  logic       rst_done;
  logic [7:0] lock_lost_cnt;

  rst_seq #(
    .NUM_STAGES (3),
    .LOCK_FILTER(LF),
    .HOLD_CYCLES(HC),
    .STAGE_GAP  (G)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .soft_rst_req (soft_rst_req),
    .stage_rst    (stage_rst),
    .rst_done     (rst_done),
    .lock_lost_cnt(lock_lost_cnt)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard of expected output changes: {stage_rst, rst_done, lock_lost_cnt}
  typedef struct {
    int          edge_n;
    logic [11:0] val;
    string       tag;
  } exp_t;
  exp_t sb[$];

  task automatic push(input int e, input logic [2:0] st, input logic dn,
                      input logic [7:0] c, input string tag);
    exp_t x;
    x.edge_n = e;
    x.val    = {st, dn, c};
    x.tag    = tag;
    sb.push_back(x);
  endtask

  task automatic push_release(input int e0, input logic [7:0] c, input string p);
    push(e0,         3'b110, 1'b0, c, {p, "_s0"});
    push(e0 + G,     3'b100, 1'b0, c, {p, "_s1"});
    push(e0 + 2 * G, 3'b000, 1'b1, c, {p, "_s2"});
  endtask

  // Monitor: every output change must match the head of the scoreboard.
  logic        mon_en = 1'b0;
  logic [11:0] prev = '0;
  always @(negedge clk) begin
    logic [11:0] cur;
    exp_t        e;
    cur = {stage_rst, rst_done, lock_lost_cnt};
    if (mon_en && cur !== prev) begin
      if (sb.size() == 0) begin
        chk("unexpected_change", {20'd0, cur}, {20'd0, prev});
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_edge"}, edge_cnt, e.edge_n);
        chk({e.tag, "_val"}, {20'd0, cur}, {20'd0, e.val});
      end
    end
    prev = cur;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input int max);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max) begin
      cyc(1);
      n++;
    end
    chk("drain", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int exp_cnt;

    // Reset state
    cyc(3);
    chk("rst_stage", stage_rst, 3'b111);
    chk("rst_done0", rst_done, 1'b0);
    chk("rst_cnt", lock_lost_cnt, 8'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    cyc(2);

    // Power-up sequence
    pll_locked = 1'b1;
    b = edge_cnt;
    push_release(b + T0, 8'd0, "pwr");
    wait_drain(60);
    cyc(5);
    chk("pwr_done", rst_done, 1'b1);
    chk("pwr_stage", stage_rst, 3'b000);

    // Lock loss in DONE
    pll_locked = 1'b0;
    b = edge_cnt;
    push(b + 3, 3'b111, 1'b0, 8'd1, "loss_done");
    wait_drain(10);
    cyc(4);

    // Re-lock with a one-cycle glitch: filter restarts, 4 edges later
    pll_locked = 1'b1;
    b = edge_cnt;
    cyc(3);
    pll_locked = 1'b0;
    cyc(1);
    pll_locked = 1'b1;
    push_release(b + 4 + T0, 8'd1, "glitch");
    wait_drain(60);
    cyc(3);

    // Lock loss while only stage 0 is released
    pll_locked = 1'b0;
    b = edge_cnt;
    push(b + 3, 3'b111, 1'b0, 8'd2, "loss2");
    wait_drain(10);
    cyc(4);
    pll_locked = 1'b1;
    b = edge_cnt;
    push(b + T0, 3'b110, 1'b0, 8'd2, "rel_s0");
    push(b + T0 + 2, 3'b111, 1'b0, 8'd3, "rel_loss");
    cyc(T0 - 1);
    pll_locked = 1'b0;
    wait_drain(20);
    cyc(6);
    chk("rel_loss_stage", stage_rst, 3'b111);
    pll_locked = 1'b1;
    b = edge_cnt;
    push_release(b + T0, 8'd3, "relock");
    wait_drain(60);
    cyc(2);

    // One-cycle soft reset in DONE, plus an ignored pulse during HOLD
    soft_rst_req = 1'b1;
    b = edge_cnt;
    push(b + 1, 3'b111, 1'b0, 8'd3, "soft");
    push_release(b + 1 + HC, 8'd3, "soft");
    cyc(1);
    soft_rst_req = 1'b0;
    cyc(3);
    soft_rst_req = 1'b1;
    cyc(1);
    soft_rst_req = 1'b0;
    wait_drain(60);
    cyc(2);

    // Soft request held high: re-triggers on the first edge in DONE
    soft_rst_req = 1'b1;
    b = edge_cnt;
    push(b + 1, 3'b111, 1'b0, 8'd3, "held");
    push_release(b + 1 + HC, 8'd3, "held");
    push(b + 2 + HC + 2 * G, 3'b111, 1'b0, 8'd3, "held_again");
    push_release(b + 2 + 2 * HC + 2 * G, 8'd3, "held2");
    cyc(2 + HC + 2 * G);
    soft_rst_req = 1'b0;
    wait_drain(60);
    cyc(2);

    // Lock loss and soft request on the same edge: lock loss wins
    pll_locked = 1'b0;
    b = edge_cnt;
    push(b + 3, 3'b111, 1'b0, 8'd4, "both");
    cyc(2);
    soft_rst_req = 1'b1;
    cyc(1);
    soft_rst_req = 1'b0;
    cyc(6);
    chk("both_drain", sb.size(), 0);
    pll_locked = 1'b1;
    b = edge_cnt;
    push_release(b + T0, 8'd4, "both_relock");
    wait_drain(60);
    cyc(2);

    // Saturation: 260 lock-loss events
    pll_locked = 1'b0;
    b = edge_cnt;
    exp_cnt = 5;
    push(b + 3, 3'b111, 1'b0, 8'(exp_cnt), "sat_first");
    cyc(5);
    for (int i = 0; i < 259; i++) begin
      pll_locked = 1'b1;
      b = edge_cnt;
      cyc(4);
      pll_locked = 1'b0;
      if (exp_cnt < 255) begin
        exp_cnt++;
        push(b + 7, 3'b111, 1'b0, 8'(exp_cnt), "sat");
      end
      cyc(4);
    end
    wait_drain(20);
    chk("sat_cnt", lock_lost_cnt, 8'd255);

    // Asynchronous reset between clock edges mid-RELEASE
    pll_locked = 1'b1;
    b = edge_cnt;
    push(b + T0, 3'b110, 1'b0, 8'd255, "pre_arst");
    cyc(T0 + 1);
    wait_drain(5);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_stage", stage_rst, 3'b111);
    chk("arst_done", rst_done, 1'b0);
    chk("arst_cnt", lock_lost_cnt, 8'd0);
    cyc(2);
    chk("arst_hold_stage", stage_rst, 3'b111);
    rst_n = 1'b1;
    b = edge_cnt;
    cyc(1);
    mon_en = 1'b1;
    push_release(b + T0, 8'd0, "post_arst");
    wait_drain(60);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
